// File: rtl/ones_stream_pkg.sv
// Shared types and helpers for the ones-stream transmitter.
package ones_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_FRAME_LEN = 15;
  localparam int DEFAULT_IDX_W     = $clog2(DEFAULT_FRAME_LEN + 1);

  // The index must be able to hold FRAME_LEN itself so it never wraps inside a frame.
  function automatic int idx_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

  function automatic int clamp_k(input int ones_in, input int frame_len);
    return (ones_in > frame_len) ? frame_len : ones_in;
  endfunction

endpackage

// File: rtl/ones_spreader.sv
// Bresenham accumulator that spreads k ones evenly over a FRAME_LEN-bit frame.
module ones_spreader
  import ones_stream_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  input  logic [WIDTH-1:0] k,
  output logic             o_bit
);

  localparam logic [WIDTH:0] FL_V = (WIDTH + 1)'(FRAME_LEN);

  logic [WIDTH:0] r_acc;
  logic [WIDTH:0] w_sum;

  // acc stays below FRAME_LEN and k is clamped, so the sum fits in WIDTH+1 bits.
  assign w_sum = r_acc + {1'b0, k};
  assign o_bit = (w_sum >= FL_V);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_acc <= '0;
    end else if (step) begin
      r_acc <= o_bit ? (w_sum - FL_V) : w_sum;
    end
  end

endmodule

// File: rtl/ones_stream_tx.sv
// Serial frame generator: emits FRAME_LEN bits holding exactly min(ones_in, FRAME_LEN) ones.
// Build option ONES_STREAM_SPREAD_EN spreads the ones evenly instead of thermometer ordering.
module ones_stream_tx
  import ones_stream_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_ones_in,
  output logic             o_bits,
  output logic             o_bit_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam int               IDX_W    = idx_width(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_k;
  logic             w_accept;
  logic             w_last;
  logic             w_bit;
  logic             w_vld;
  logic             w_busy;
  logic             w_done;
  logic             r_bits;
  logic             r_bit_valid;
  logic             r_busy;
  logic             r_done;

  assign w_accept = (r_state == IDLE) && i_start;
  assign w_last   = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = SEND;
      SEND:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_vld  = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      SEND: begin
        w_vld  = 1'b1;
        w_busy = 1'b1;
      end
      DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
      r_k   <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
      r_k   <= WIDTH'(clamp_k(int'(i_ones_in), FRAME_LEN));
    end else if (r_state == SEND) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

`ifdef ONES_STREAM_SPREAD_EN
  ones_spreader #(
    .WIDTH    (WIDTH),
    .FRAME_LEN(FRAME_LEN)
  ) u_spreader (
    .clk  (clk),
    .reset(reset),
    .clear(w_accept),
    .step (w_vld),
    .k    (r_k),
    .o_bit(w_bit)
  );
`else
  assign w_bit = (WIDTH'(r_idx) < r_k);
`endif

  // Outputs trail the state by one cycle; bits is forced low outside a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bits      <= 1'b0;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_bits      <= w_vld & w_bit;
      r_bit_valid <= w_vld;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign o_bits      = r_bits;
  assign o_bit_valid = r_bit_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_ones_stream_tx.sv
// Directed bench for ones_stream_tx; expected frames follow the selected ordering (ONES_STREAM_SPREAD_EN).
module tb_ones_stream_tx;

  localparam int W   = 4;
  localparam int FL  = 15;
  localparam int FL2 = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, start2;
  logic [W-1:0] ones, ones2;
  logic         bits, vld, busy, done;
  logic         bits2, vld2, busy2, done2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ones_stream_tx #(.WIDTH(W), .FRAME_LEN(FL)) u_dut (
    .clk(clk), .reset(reset), .i_start(start), .i_ones_in(ones),
    .o_bits(bits), .o_bit_valid(vld), .o_busy(busy), .o_done(done)
  );

  ones_stream_tx #(.WIDTH(W), .FRAME_LEN(FL2)) u_dut10 (
    .clk(clk), .reset(reset), .i_start(start2), .i_ones_in(ones2),
    .o_bits(bits2), .o_bit_valid(vld2), .o_busy(busy2), .o_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input int i, input int k, input int fl);
`ifdef ONES_STREAM_SPREAD_EN
    return (((i + 1) * k) / fl) > ((i * k) / fl);
`else
    return i < k;
`endif
  endfunction

  task automatic run_frame(input int req, input string tag, output logic [31:0] mask);
    int k, ones_cnt, vld_cnt, busy_cnt, done_cnt;
    logic [31:0] exp_m;
    k = (req > FL) ? FL : req;
    mask = '0; exp_m = '0;
    ones_cnt = 0; vld_cnt = 0; busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < FL; i++) exp_m[i] = exp_bit(i, k, FL);
    @(negedge clk); start = 1'b1; ones = W'(req);
    @(posedge clk); #1; start = 1'b0;
    check({tag, "_accept_vld"}, {31'd0, vld}, 32'd0);
    for (int c = 1; c <= FL; c++) begin
      @(posedge clk); #1;
      mask[c-1] = bits;
      if (bits === 1'b1) ones_cnt++;
      if (vld === 1'b1) vld_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
    end
    check({tag, "_mask"}, mask, exp_m);
    check({tag, "_pop"}, ones_cnt, k);
    check({tag, "_vld_cnt"}, vld_cnt, FL);
    check({tag, "_busy_cnt"}, busy_cnt, FL);
    check({tag, "_early_done"}, done_cnt, 0);
    @(posedge clk); #1;
    check({tag, "_done"}, {29'd0, done, busy, vld}, 32'b110);
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] m;
    logic        s_vld [0:79];
    logic        s_busy[0:79];
    int          rises[$];
    int          cnt, vc;

    reset = 1'b1; start = 1'b0; start2 = 1'b0; ones = '0; ones2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {28'd0, bits, vld, busy, done}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("idle_outs", {28'd0, bits, vld, busy, done}, 32'd0);

    run_frame(5, "k5", m);
`ifdef ONES_STREAM_SPREAD_EN
    check("k5_pattern", m, 32'h0000_4924);
`else
    check("k5_pattern", m, 32'h0000_001F);
`endif
    run_frame(0, "k0", m);
    check("k0_pattern", m, 32'h0000_0000);
    run_frame(15, "k15", m);
    check("k15_pattern", m, 32'h0000_7FFF);

    // FRAME_LEN=10 instance with an over-range request
    @(negedge clk); start2 = 1'b1; ones2 = 4'd12;
    @(posedge clk); #1; start2 = 1'b0;
    cnt = 0; vc = 0;
    for (int c = 1; c <= FL2; c++) begin
      @(posedge clk); #1;
      if (bits2 === 1'b1) cnt++;
      if (vld2 === 1'b1) vc++;
    end
    check("fl10_pop", cnt, 10);
    check("fl10_vld_cnt", vc, 10);
    @(posedge clk); #1;
    check("fl10_done", {30'd0, done2, busy2}, 32'b11);

    // start held high continuously
    @(negedge clk); start = 1'b1; ones = 4'd5;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      s_vld[c] = vld; s_busy[c] = busy;
    end
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (s_vld[c] === 1'b1 && (c == 0 || s_vld[c-1] !== 1'b1)) rises.push_back(c);
    end
    check("held_frames", rises.size(), 5);
    if (rises.size() >= 3) begin
      check("held_first", rises[0], 1);
      check("held_gap1", rises[1] - rises[0], 17);
      check("held_gap2", rises[2] - rises[1], 17);
      cnt = 0;
      for (int c = rises[0]; c < rises[1]; c++) if (s_busy[c] === 1'b1) cnt++;
      check("held_busy_cnt", cnt, 16);
      check("held_busy_gap", {31'd0, s_busy[rises[1]-1]}, 32'd0);
    end else begin
      check("held_rises_found", rises.size(), 3);
    end
    repeat (20) @(posedge clk);

    // reset while bit index 7 is on the output
    @(negedge clk); start = 1'b1; ones = 4'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("rst_pre_vld", {31'd0, vld}, 32'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_outs", {28'd0, bits, vld, busy, done}, 32'd0);
    @(negedge clk); reset = 1'b0;
    cnt = 0; vc = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
      if (busy === 1'b1) vc++;
    end
    check("rst_no_done", cnt, 0);
    check("rst_no_busy", vc, 0);
    run_frame(3, "after_rst", m);
    check("after_rst_pattern", $countones(m), 3);

    for (int n = 0; n < 200; n++) begin
      run_frame(int'($urandom_range(0, 15)), "rand", m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
